// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory map.
//   region_e       : decoded target of a CPU data access
//   DEF_*          : default geometry of the standard Hack memory map
//   clog2()        : constant-function ceiling log2 used for port and pointer widths
package hack_mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_SCREEN   = 2'd1,
    REG_KBD      = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 15;
  localparam int DEF_RAM_WORDS    = 16384;
  localparam int DEF_SCREEN_BASE  = 16384;
  localparam int DEF_SCREEN_WORDS = 8192;
  localparam int DEF_KBD_ADDR     = 24576;
  localparam int DEF_KBD_W        = 8;
  localparam int DEF_FIFO_DEPTH   = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/hack_mem_wr_fifo.sv
// Synchronous write FIFO carrying screen writes from the CPU side to the
// screen controller.
//   clk, reset : rising-edge clock, synchronous active-high reset (empties FIFO)
//   push_i     : enqueue data_i (honoured when not full, or full with a pop)
//   pop_i      : dequeue head (ignored when empty)
//   data_o     : current head entry, stable until popped
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module hack_mem_wr_fifo
  import hack_mem_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hack_memory_map.sv
// Hack data-memory map: decodes the CPU data address into RAM, screen and
// keyboard regions.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in          : CPU write data
//   address     : CPU data address
//   load        : CPU write strobe
//   out         : read data, one cycle after the address
//   stall       : CPU must hold load/address/in (screen FIFO full, no pop)
//   keyboard    : raw keycode, 0 = no key
//   scr_valid   : screen FIFO head valid
//   scr_ready   : screen controller accepts the head
//   scr_addr    : screen word offset of the head entry
//   scr_data    : pixel word of the head entry
// Build option HACK_MEM_SCREEN_SHADOW_EN: keeps a shadow copy of the screen so
// screen reads return per-address content. Without it, screen reads return the
// last accepted screen write word regardless of address.
module hack_memory_map
  import hack_mem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int RAM_WORDS    = DEF_RAM_WORDS,
  parameter int SCREEN_BASE  = DEF_SCREEN_BASE,
  parameter int SCREEN_WORDS = DEF_SCREEN_WORDS,
  parameter int KBD_ADDR     = DEF_KBD_ADDR,
  parameter int KBD_W        = DEF_KBD_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               in,
  input  logic [ADDR_W-1:0]               address,
  input  logic                            load,
  output logic [DATA_W-1:0]               out,
  output logic                            stall,
  input  logic [KBD_W-1:0]                keyboard,
  output logic                            scr_valid,
  input  logic                            scr_ready,
  output logic [clog2(SCREEN_WORDS)-1:0]  scr_addr,
  output logic [DATA_W-1:0]               scr_data
);

  localparam int SCR_AW = clog2(SCREEN_WORDS);
  localparam int RAM_AW = clog2(RAM_WORDS);
  localparam int FIFO_W = SCR_AW + DATA_W;

  // Region bounds are held one bit wider than the address so an end bound of
  // 2**ADDR_W is representable and no bound aliases onto a low address.
  localparam logic [ADDR_W:0]   RAM_END    = (ADDR_W+1)'(RAM_WORDS);
  localparam logic [ADDR_W:0]   SCR_LO     = (ADDR_W+1)'(SCREEN_BASE);
  localparam logic [ADDR_W:0]   SCR_HI     = (ADDR_W+1)'(SCREEN_BASE + SCREEN_WORDS);
  localparam logic [ADDR_W:0]   KBD_A      = (ADDR_W+1)'(KBD_ADDR);
  localparam logic [SCR_AW-1:0] SCR_BASE_T = SCR_AW'(SCREEN_BASE);

  region_e            region_d, region_q;
  logic [ADDR_W:0]    addr_ext;
  logic [SCR_AW-1:0]  scr_off;
  logic               ram_we, scr_hit, scr_pop, scr_push, scr_accept;
  logic               fifo_full, fifo_empty;
  logic [FIFO_W-1:0]  fifo_head;
  logic [KBD_W-1:0]   kbd_q;
  logic [DATA_W-1:0]  ram_q [RAM_WORDS];
  logic [DATA_W-1:0]  ram_rd_q;
  logic [DATA_W-1:0]  scr_rd_data;

  assign addr_ext = {1'b0, address};

  always_comb begin
    region_d = REG_UNMAPPED;
    if (addr_ext < RAM_END)                          region_d = REG_RAM;
    else if ((addr_ext >= SCR_LO) && (addr_ext < SCR_HI)) region_d = REG_SCREEN;
    else if (addr_ext == KBD_A)                      region_d = REG_KBD;
  end

  // Offset is only meaningful inside the screen window; modular subtraction
  // at SCR_AW bits gives the exact offset there.
  assign scr_off = address[SCR_AW-1:0] - SCR_BASE_T;

  assign ram_we     = load & (region_d == REG_RAM);
  assign scr_hit    = load & (region_d == REG_SCREEN);
  assign scr_pop    = scr_valid & scr_ready;
  assign stall      = scr_hit & fifo_full & ~scr_pop;
  assign scr_push   = scr_hit & ~stall;
  assign scr_accept = scr_push & ~reset;

  hack_mem_wr_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (scr_push),
    .data_i  ({scr_off, in}),
    .pop_i   (scr_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign scr_valid            = ~fifo_empty;
  assign {scr_addr, scr_data} = fifo_head;

  // Single-port RAM; a write forwards the new word to the read register.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[address[RAM_AW-1:0]] <= in;
      ram_rd_q                   <= in;
    end else begin
      ram_rd_q <= ram_q[address[RAM_AW-1:0]];
    end
  end

`ifdef HACK_MEM_SCREEN_SHADOW_EN
  logic [DATA_W-1:0] shadow_q [SCREEN_WORDS];
  logic [DATA_W-1:0] shadow_rd_q;

  always_ff @(posedge clk) begin
    if (scr_accept) begin
      shadow_q[scr_off] <= in;
      shadow_rd_q       <= in;
    end else begin
      shadow_rd_q <= shadow_q[scr_off];
    end
  end

  assign scr_rd_data = shadow_rd_q;
`else
  logic [DATA_W-1:0] last_q;

  always_ff @(posedge clk) begin
    if (reset)           last_q <= '0;
    else if (scr_accept) last_q <= in;
  end

  assign scr_rd_data = last_q;
`endif

  // Resetting the registered region to UNMAPPED is what forces out to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      region_q <= REG_UNMAPPED;
      kbd_q    <= '0;
    end else begin
      region_q <= region_d;
      kbd_q    <= keyboard;
    end
  end

  always_comb begin
    out = '0;
    case (region_q)
      REG_RAM:    out = ram_rd_q;
      REG_SCREEN: out = scr_rd_data;
      REG_KBD:    out = DATA_W'(kbd_q);
      default:    out = '0;
    endcase
  end

endmodule
